butterfly_ctrl: RTL and testbench
=================================

# butterfly_ctrl

Sequencing controller for the FFT butterfly operand registers. It debounces the single `ReadyIn` push-button and turns each accepted press into a one-cycle load strobe for the next operand register, in the order Rew, Imw, Reb, Imb, Rea, Ima. It then waits a fixed compute latency and steps the result display through Re z and Im z. Its outputs drive the load/display inputs of the operand register bank directly and light the stage LEDs.

## Interface
- `DEB`, default 4: debounce length in cycles; the synchronised button must be stable this long before a level change is accepted; ≥1.
- `LAT`, default 3: butterfly compute latency in cycles spent in CALC; ≥1.
- `clk`  in  1: system clock; all logic on rising edge.
- `Rst`  in  1: reset, synchronous, active-high.
- `ReadyIn`  in  1: raw push-button level, asynchronous to `clk`.
- `load_Rew`, `load_Imw`, `load_Reb`, `load_Imb`, `load_Rea`, `load_Ima`  out  1 each: one-cycle load strobes.
- `start`  out  1: one-cycle pulse on entry to CALC.
- `busy`  out  1: high while in CALC.
- `display_Rez`, `display_Imz`  out  1 each: high while in SHOW_REZ and SHOW_IMZ respectively.
- `stage`  out  4: current state code for the LEDs.

## Operation
**Input conditioning**
- `ReadyIn` passes through a 2-flop synchroniser to give `sync`.
- A debounce counter runs while `sync` ≠ `acc` (the accepted level). It clears whenever `sync` = `acc`.
- When the counter reaches `DEB` consecutive differing cycles, `acc` takes the value of `sync` and the counter clears.
- `press` is the rising edge of `acc`; it is internal and one cycle wide.

**States and `stage` codes**
- LOAD_REW = 0, LOAD_IMW = 1, LOAD_REB = 2, LOAD_IMB = 3, LOAD_REA = 4, LOAD_IMA = 5, CALC = 6, SHOW_REZ = 7, SHOW_IMZ = 8.
- Codes 9–15 are illegal; they go to LOAD_REW on the next edge with all strobes low.

**Transitions**
- In LOAD_x, `press` does two things on the same edge: it asserts `load_x` for exactly one cycle, and it advances the state to the next in order.
- LOAD_IMA + `press` → CALC. `start` is high for the first CALC cycle only.
- A cycle counter holds CALC for exactly `LAT` cycles, then the state goes to SHOW_REZ.
- SHOW_REZ + `press` → SHOW_IMZ.
- SHOW_IMZ + `press` → LOAD_REB. The twiddle factor is retained, so Rew/Imw are reloaded only after reset.
- `press` in CALC is discarded, not queued.
- Only one strobe output is ever high in any cycle.

## Timing
- **Reset values:** on an `Rst`-high edge all outputs are 0, `stage` = 0, and the synchroniser flops, `acc` and both counters are 0. `Rst` overrides every other input.
- **Press latency:** let E0 be the first edge that samples `ReadyIn` = 1, with the button held. `sync` rises at E0+1 and `acc` at E0+1+`DEB`. The load strobe is high from edge E0+2+`DEB` to E0+3+`DEB`.
  - With `DEB` = 4 the strobe is high in cycle E0+6 only.
- **Bounce rejection:** a `ReadyIn` glitch, either high or low, shorter than `DEB` synchronised cycles changes nothing.
- **Release required:** holding the button gives exactly one press. A new press needs `acc` to return to 0 first, which is itself debounced.
- **CALC timing:** entered at edge T; `start` and `busy` are high in cycle T; `busy` stays high for `LAT` cycles. `display_Rez` rises at edge T+`LAT`.
- **Press landing on the CALC→SHOW_REZ edge:** discarded.
- **`ReadyIn` high through reset release:** `acc` is 0 after reset, so the held button produces one press `DEB`+2 edges after release and loads Rew.
- **Reset mid-sequence, including mid-CALC:** the next edge returns to LOAD_REW with no strobe emitted.

## Test plan
- **Reset:** assert `Rst` for 2 cycles with `ReadyIn` = 0 → all outputs 0, `stage` = 0; no strobe for 20 idle cycles.
- **Full pass (`DEB` = 4, `LAT` = 3):** six clean presses, each 10 cycles high and 10 low.
  - Required response: strobes in order Rew, Imw, Reb, Imb, Rea, Ima, each one cycle wide, 6 cycles after its E0.
  - Then `start` for one cycle, `busy` for 3 cycles, then `display_Rez` = 1 and `stage` = 7.
- **Bounce:** in LOAD_REW, pulse `ReadyIn` high for 2 cycles, low 2, high 3, low → no strobe, `stage` stays 0. A following 10-cycle press gives exactly one `load_Rew`.
- **CALC discard:** press during CALC → no strobe, `stage` reaches 7 on schedule, `display_Imz` stays 0.
- **Loop:** from SHOW_REZ, press → `display_Imz` = 1, `stage` = 8; press again → `stage` = 2, and the next press strobes `load_Reb`, not `load_Rew`.
- **Reset mid-operation:** assert `Rst` one cycle in LOAD_IMB, and separately in CALC cycle 2 → `stage` = 0 and `busy` = 0 next cycle; the next press strobes `load_Rew`.

Source files
------------

// File: rtl/butterfly_ctrl.sv
// Sequencing controller for the FFT butterfly operand registers: debounces the
// ReadyIn button and steps the operand loads, compute wait and result display.
module butterfly_ctrl #(
   parameter int DEB = 4,
   parameter int LAT = 3
) (
   input  logic       clk,
   input  logic       Rst,
   input  logic       ReadyIn,
   output logic       load_Rew,
   output logic       load_Imw,
   output logic       load_Reb,
   output logic       load_Imb,
   output logic       load_Rea,
   output logic       load_Ima,
   output logic       start,
   output logic       busy,
   output logic       display_Rez,
   output logic       display_Imz,
   output logic [3:0] stage
);

   localparam logic [3:0] LOAD_REW = 4'd0;
   localparam logic [3:0] LOAD_IMW = 4'd1;
   localparam logic [3:0] LOAD_REB = 4'd2;
   localparam logic [3:0] LOAD_IMB = 4'd3;
   localparam logic [3:0] LOAD_REA = 4'd4;
   localparam logic [3:0] LOAD_IMA = 4'd5;
   localparam logic [3:0] CALC     = 4'd6;
   localparam logic [3:0] SHOW_REZ = 4'd7;
   localparam logic [3:0] SHOW_IMZ = 4'd8;

   localparam int DEB_W = $clog2(DEB + 1);
   localparam int LAT_W = $clog2(LAT + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAT - 1);

   logic             sync_meta;
   logic             sync;
   logic             acc;
   logic             acc_prev;
   logic [DEB_W-1:0] deb_cnt;
   logic             press;
   logic [3:0]       state;
   logic [LAT_W-1:0] lat_cnt;

   // The accepted level only follows sync after DEB consecutive differing cycles.
   always_ff @(posedge clk) begin
      if (Rst) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
         acc       <= 1'b0;
         acc_prev  <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         sync_meta <= ReadyIn;
         sync      <= sync_meta;
         acc_prev  <= acc;
         if (sync != acc) begin
            if (deb_cnt == DEB_LAST) begin
               acc     <= sync;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   assign press = acc & ~acc_prev;

   // Strobes are registered so each press yields exactly one clean cycle.
   always_ff @(posedge clk) begin
      if (Rst) begin
         state    <= LOAD_REW;
         lat_cnt  <= '0;
         load_Rew <= 1'b0;
         load_Imw <= 1'b0;
         load_Reb <= 1'b0;
         load_Imb <= 1'b0;
         load_Rea <= 1'b0;
         load_Ima <= 1'b0;
         start    <= 1'b0;
      end else begin
         load_Rew <= 1'b0;
         load_Imw <= 1'b0;
         load_Reb <= 1'b0;
         load_Imb <= 1'b0;
         load_Rea <= 1'b0;
         load_Ima <= 1'b0;
         start    <= 1'b0;
         case (state)
            LOAD_REW: if (press) begin load_Rew <= 1'b1; state <= LOAD_IMW; end
            LOAD_IMW: if (press) begin load_Imw <= 1'b1; state <= LOAD_REB; end
            LOAD_REB: if (press) begin load_Reb <= 1'b1; state <= LOAD_IMB; end
            LOAD_IMB: if (press) begin load_Imb <= 1'b1; state <= LOAD_REA; end
            LOAD_REA: if (press) begin load_Rea <= 1'b1; state <= LOAD_IMA; end
            LOAD_IMA: begin
               if (press) begin
                  load_Ima <= 1'b1;
                  start    <= 1'b1;
                  lat_cnt  <= '0;
                  state    <= CALC;
               end
            end
            CALC: begin
               // Presses arriving here are dropped, including on the exit edge.
               if (lat_cnt == LAT_LAST) begin
                  lat_cnt <= '0;
                  state   <= SHOW_REZ;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            SHOW_REZ: if (press) state <= SHOW_IMZ;
            // The twiddle factor stays loaded, so the loop resumes at Reb.
            SHOW_IMZ: if (press) state <= LOAD_REB;
            default: begin
               state   <= LOAD_REW;
               lat_cnt <= '0;
            end
         endcase
      end
   end

   assign busy        = (state == CALC);
   assign display_Rez = (state == SHOW_REZ);
   assign display_Imz = (state == SHOW_IMZ);
   assign stage       = state;

endmodule

// File: tb/tb_butterfly_ctrl.sv
// Directed bench for butterfly_ctrl; a second instance with a long compute
// latency makes a press inside CALC reachable.
module tb_butterfly_ctrl;

   logic       clk;
   logic       Rst;
   logic       ReadyIn;

   logic       load_Rew1, load_Imw1, load_Reb1, load_Imb1, load_Rea1, load_Ima1;
   logic       start1, busy1, rez1, imz1;
   logic [3:0] stage1;
   logic       load_Rew2, load_Imw2, load_Reb2, load_Imb2, load_Rea2, load_Ima2;
   logic       start2, busy2, rez2, imz2;
   logic [3:0] stage2;

   logic [5:0] strobe1;
   logic [5:0] strobe2;

   int n_cmp;
   int n_bad;

   logic [5:0] rec_strobe [64];
   logic       rec_start  [64];
   logic       rec_busy   [64];
   logic       rec_rez    [64];
   logic       rec_imz    [64];
   logic [3:0] rec_stage  [64];
   logic [5:0] rec_strobe2 [64];
   logic       rec_busy2  [64];
   logic       rec_imz2   [64];
   logic [3:0] rec_stage2 [64];
   int rec_n;

   butterfly_ctrl #(.DEB(4), .LAT(3)) dut (
      .clk(clk), .Rst(Rst), .ReadyIn(ReadyIn),
      .load_Rew(load_Rew1), .load_Imw(load_Imw1), .load_Reb(load_Reb1),
      .load_Imb(load_Imb1), .load_Rea(load_Rea1), .load_Ima(load_Ima1),
      .start(start1), .busy(busy1), .display_Rez(rez1), .display_Imz(imz1),
      .stage(stage1)
   );

   butterfly_ctrl #(.DEB(4), .LAT(16)) dut_long (
      .clk(clk), .Rst(Rst), .ReadyIn(ReadyIn),
      .load_Rew(load_Rew2), .load_Imw(load_Imw2), .load_Reb(load_Reb2),
      .load_Imb(load_Imb2), .load_Rea(load_Rea2), .load_Ima(load_Ima2),
      .start(start2), .busy(busy2), .display_Rez(rez2), .display_Imz(imz2),
      .stage(stage2)
   );

   assign strobe1 = {load_Rew1, load_Imw1, load_Reb1, load_Imb1, load_Rea1, load_Ima1};
   assign strobe2 = {load_Rew2, load_Imw2, load_Reb2, load_Imb2, load_Rea2, load_Ima2};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_rec();
      rec_n = 0;
   endtask

   // Hold the button at lvl for n edges, recording both instances after each edge.
   task automatic drive(input logic lvl, input int n);
      ReadyIn = lvl;
      for (int k = 0; k < n; k++) begin
         tick();
         rec_strobe[rec_n]  = strobe1;
         rec_start[rec_n]   = start1;
         rec_busy[rec_n]    = busy1;
         rec_rez[rec_n]     = rez1;
         rec_imz[rec_n]     = imz1;
         rec_stage[rec_n]   = stage1;
         rec_strobe2[rec_n] = strobe2;
         rec_busy2[rec_n]   = busy2;
         rec_imz2[rec_n]    = imz2;
         rec_stage2[rec_n]  = stage2;
         rec_n++;
      end
   endtask

   task automatic press_once();
      start_rec();
      drive(1'b1, 10);
      drive(1'b0, 10);
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      ReadyIn = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({strobe1, start1, busy1, rez1, imz1, stage1} !== 14'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b want %b", {strobe1, start1, busy1, rez1, imz1, stage1}, 14'd0);
      end
      Rst = 1'b0;
      start_rec();
      drive(1'b0, 20);
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if (rec_strobe[i] !== 6'd0 || rec_stage[i] !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_idle tick %0d: got strobe %b stage %0d want 000000 stage 0", i + 1, rec_strobe[i], rec_stage[i]);
         end
      end
   endtask

   task automatic test_full_pass();
      logic [5:0] exp_s;
      logic [3:0] exp_st;
      for (int k = 0; k < 5; k++) begin
         press_once();
         for (int i = 0; i < 20; i++) begin
            exp_s = (i == 6) ? (6'b100000 >> k) : 6'd0;
            n_cmp++;
            if (rec_strobe[i] !== exp_s) begin
               n_bad++;
               $display("FAIL full_strobe press %0d tick %0d: got %b want %b", k, i + 1, rec_strobe[i], exp_s);
            end
         end
         n_cmp++;
         if (rec_stage[19] !== 4'(k + 1)) begin
            n_bad++;
            $display("FAIL full_stage press %0d: got %0d want %0d", k, rec_stage[19], k + 1);
         end
      end
      press_once();
      for (int i = 0; i < 20; i++) begin
         exp_s  = (i == 6) ? 6'b000001 : 6'd0;
         exp_st = (i < 6) ? 4'd5 : (i < 9) ? 4'd6 : 4'd7;
         n_cmp++;
         if (rec_strobe[i] !== exp_s || rec_start[i] !== (i == 6) || rec_busy[i] !== (i >= 6 && i <= 8)
             || rec_rez[i] !== (i >= 9) || rec_stage[i] !== exp_st) begin
            n_bad++;
            $display("FAIL full_calc tick %0d: got strobe %b start %b busy %b rez %b stage %0d want strobe %b start %b busy %b rez %b stage %0d",
                     i + 1, rec_strobe[i], rec_start[i], rec_busy[i], rec_rez[i], rec_stage[i],
                     exp_s, (i == 6), (i >= 6 && i <= 8), (i >= 9), exp_st);
         end
      end
   endtask

   task automatic test_loop();
      press_once();
      n_cmp++;
      if (rec_stage[5] !== 4'd7 || rec_stage[6] !== 4'd8 || rec_imz[6] !== 1'b1 || rec_rez[6] !== 1'b0) begin
         n_bad++;
         $display("FAIL loop_show_imz: got stage %0d->%0d imz %b rez %b want 7->8 imz 1 rez 0", rec_stage[5], rec_stage[6], rec_imz[6], rec_rez[6]);
      end
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if (rec_strobe[i] !== 6'd0) begin
            n_bad++;
            $display("FAIL loop_no_strobe tick %0d: got %b want 000000", i + 1, rec_strobe[i]);
         end
      end
      press_once();
      n_cmp++;
      if (rec_stage[6] !== 4'd2 || rec_imz[6] !== 1'b0 || rec_strobe[6] !== 6'd0) begin
         n_bad++;
         $display("FAIL loop_wrap: got stage %0d imz %b strobe %b want stage 2 imz 0 strobe 000000", rec_stage[6], rec_imz[6], rec_strobe[6]);
      end
      press_once();
      n_cmp++;
      if (rec_strobe[6] !== 6'b001000 || rec_stage[19] !== 4'd3) begin
         n_bad++;
         $display("FAIL loop_reb: got strobe %b stage %0d want 001000 stage 3", rec_strobe[6], rec_stage[19]);
      end
   endtask

   task automatic test_reset_mid();
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      n_cmp++;
      if (stage1 !== 4'd0 || busy1 !== 1'b0 || strobe1 !== 6'd0) begin
         n_bad++;
         $display("FAIL mid_reset_imb: got stage %0d busy %b strobe %b want 0 0 000000", stage1, busy1, strobe1);
      end
      press_once();
      n_cmp++;
      if (rec_strobe[6] !== 6'b100000) begin
         n_bad++;
         $display("FAIL mid_reset_imb_rew: got %b want 100000", rec_strobe[6]);
      end
      for (int k = 0; k < 4; k++) press_once();
      n_cmp++;
      if (stage1 !== 4'd5) begin
         n_bad++;
         $display("FAIL mid_reach_ima: got %0d want 5", stage1);
      end
      start_rec();
      drive(1'b1, 8);
      n_cmp++;
      if (rec_busy[7] !== 1'b1 || rec_stage[7] !== 4'd6) begin
         n_bad++;
         $display("FAIL mid_calc2: got busy %b stage %0d want 1 6", rec_busy[7], rec_stage[7]);
      end
      Rst = 1'b1;
      ReadyIn = 1'b0;
      tick();
      Rst = 1'b0;
      n_cmp++;
      if (stage1 !== 4'd0 || busy1 !== 1'b0 || start1 !== 1'b0 || strobe1 !== 6'd0) begin
         n_bad++;
         $display("FAIL mid_reset_calc: got stage %0d busy %b start %b strobe %b want 0 0 0 000000", stage1, busy1, start1, strobe1);
      end
      start_rec();
      drive(1'b0, 10);
      drive(1'b1, 10);
      drive(1'b0, 10);
      for (int i = 0; i < 30; i++) begin
         n_cmp++;
         if (rec_strobe[i] !== ((i == 16) ? 6'b100000 : 6'd0)) begin
            n_bad++;
            $display("FAIL mid_calc_rew tick %0d: got %b want %b", i + 1, rec_strobe[i], (i == 16) ? 6'b100000 : 6'd0);
         end
      end
   endtask

   task automatic test_bounce();
      Rst = 1'b1;
      ReadyIn = 1'b0;
      tick();
      Rst = 1'b0;
      start_rec();
      drive(1'b1, 2);
      drive(1'b0, 2);
      drive(1'b1, 3);
      drive(1'b0, 10);
      for (int i = 0; i < 17; i++) begin
         n_cmp++;
         if (rec_strobe[i] !== 6'd0 || rec_stage[i] !== 4'd0) begin
            n_bad++;
            $display("FAIL bounce tick %0d: got strobe %b stage %0d want 000000 stage 0", i + 1, rec_strobe[i], rec_stage[i]);
         end
      end
      press_once();
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if (rec_strobe[i] !== ((i == 6) ? 6'b100000 : 6'd0)) begin
            n_bad++;
            $display("FAIL bounce_press tick %0d: got %b want %b", i + 1, rec_strobe[i], (i == 6) ? 6'b100000 : 6'd0);
         end
      end
   endtask

   task automatic test_calc_discard();
      Rst = 1'b1;
      ReadyIn = 1'b0;
      tick();
      Rst = 1'b0;
      for (int k = 0; k < 5; k++) press_once();
      n_cmp++;
      if (stage2 !== 4'd5) begin
         n_bad++;
         $display("FAIL discard_reach_ima: got %0d want 5", stage2);
      end
      start_rec();
      drive(1'b1, 7);
      drive(1'b0, 6);
      drive(1'b1, 10);
      drive(1'b0, 10);
      for (int i = 0; i < 33; i++) begin
         n_cmp++;
         if (rec_strobe2[i] !== ((i == 6) ? 6'b000001 : 6'd0) || rec_busy2[i] !== (i >= 6 && i <= 21)
             || rec_imz2[i] !== 1'b0 || (i >= 22 && rec_stage2[i] !== 4'd7)) begin
            n_bad++;
            $display("FAIL discard tick %0d: got strobe %b busy %b imz %b stage %0d want strobe %b busy %b imz 0 stage %0d",
                     i + 1, rec_strobe2[i], rec_busy2[i], rec_imz2[i], rec_stage2[i],
                     (i == 6) ? 6'b000001 : 6'd0, (i >= 6 && i <= 21), (i >= 22) ? 7 : 6);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rec_n = 0;
      Rst = 1'b1;
      ReadyIn = 1'b0;
      test_reset();
      test_full_pass();
      test_loop();
      test_reset_mid();
      test_bounce();
      test_calc_discard();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
